// File: rtl/i2c_eeprom_seq_pkg.sv
// rtl/i2c_eeprom_seq_pkg.sv - shared types and constants for the EEPROM transaction sequencer
//
// Purpose: primitive opcodes and sequencer states, plus the host frame constants
// and command codes that the USB command handler shares with this block.
// Ports: none (package).

package i2c_pkg;

  // Byte-level I2C master primitives; encodings are fixed by the master.
  typedef enum logic [2:0] {
    OP_START     = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ_ACK  = 3'd2,
    OP_READ_NACK = 3'd3,
    OP_STOP      = 3'd4
  } i2c_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV,
    S_MEM,
    S_WDATA,
    S_STOP,
    S_POLL_START,
    S_POLL_DEV,
    S_POLL_STOP,
    S_RSTART,
    S_DEV_R,
    S_RDATA,
    S_ERR_STOP,
    S_DONE
  } seq_state_e;

  // Host frame delimiters and command codes.
  localparam logic [7:0] FRAME_SYNC0  = 8'hAA;
  localparam logic [7:0] FRAME_SYNC1  = 8'h55;
  localparam logic [7:0] CMD_AUX      = 8'h04;
  localparam logic [7:0] CMD_EE_WRITE = 8'h05;
  localparam logic [7:0] CMD_EE_READ  = 8'h06;

endpackage

// File: rtl/i2c_eeprom_seq_if.sv
// rtl/i2c_eeprom_seq_if.sv - primitive command/response bus between sequencer and I2C master
//
// Purpose: one primitive in flight at a time; command handshake, then a
// one-cycle response pulse.
// Signals:
//   m_cmd_op / m_cmd_wdata / m_cmd_valid / m_cmd_ready : primitive request
//   m_rsp_valid / m_rsp_nack / m_rsp_rdata              : primitive completion
// Modports: master = sequencer side, slave = I2C master side.

interface i2c_eeprom_seq_if;
  import i2c_pkg::*;

  i2c_op_e    m_cmd_op;
  logic [7:0] m_cmd_wdata;
  logic       m_cmd_valid;
  logic       m_cmd_ready;
  logic       m_rsp_valid;
  logic       m_rsp_nack;
  logic [7:0] m_rsp_rdata;

  modport master (
    output m_cmd_op, m_cmd_wdata, m_cmd_valid,
    input  m_cmd_ready, m_rsp_valid, m_rsp_nack, m_rsp_rdata
  );

  modport slave (
    input  m_cmd_op, m_cmd_wdata, m_cmd_valid,
    output m_cmd_ready, m_rsp_valid, m_rsp_nack, m_rsp_rdata
  );

endinterface

// File: rtl/i2c_eeprom_seq.sv
// rtl/i2c_eeprom_seq.sv - EEPROM request to I2C primitive sequencer
//
// Purpose: turns one read/write request into START/byte/STOP primitives,
// splitting writes at page boundaries and ACK-polling after each page.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready, req_rw,
//   req_dev_addr, req_mem_addr,
//   req_len                          : request handshake and fields
//   wr_data/wr_valid/wr_ready        : write payload stream
//   rd_data/rd_valid                 : read data strobe
//   done, err                        : end-of-request pulse and status
//   m                                : primitive bus to the I2C master

module i2c_eeprom_seq
  import i2c_pkg::*;
#(
  parameter int PAGE_SIZE = 16,
  parameter int MAX_POLL  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_mem_addr,
  input  logic [15:0] req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  i2c_eeprom_seq_if.master m
);

  localparam int PB = $clog2(PAGE_SIZE);
  localparam int PW = $clog2(MAX_POLL + 1);

  seq_state_e    state_q, state_d;
  logic          rw_q;
  logic [6:0]    dev_q;
  logic [7:0]    addr_q;
  logic [15:0]   remaining_q;
  logic [PW-1:0] poll_cnt_q;
  logic          err_q;
  logic          cmd_valid_q;
  logic          wait_rsp_q;
  i2c_op_e       op_q, op_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          bus_state, idle_phase, issue, rsp_ok, accept, last_poll;

  // idle_phase: nothing handed to the master yet in the current state.
  assign idle_phase = !cmd_valid_q && !wait_rsp_q;
  // Responses while the command is still being offered are ignored.
  assign rsp_ok     = wait_rsp_q && m.m_rsp_valid;
  assign accept     = (state_q == S_IDLE) && req_valid;
  assign last_poll  = (poll_cnt_q == PW'(MAX_POLL - 1));

  assign req_ready     = (state_q == S_IDLE) && rst_n;
  assign done          = (state_q == S_DONE);
  assign err           = done && err_q;
  assign m.m_cmd_valid = cmd_valid_q;
  assign m.m_cmd_op    = op_q;
  assign m.m_cmd_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    op_d      = OP_STOP;
    wdata_d   = 8'h00;
    bus_state = 1'b1;
    case (state_q)
      S_START, S_RSTART, S_POLL_START: op_d = OP_START;
      S_DEV, S_POLL_DEV: begin op_d = OP_WRITE; wdata_d = {dev_q, 1'b0}; end
      S_DEV_R:           begin op_d = OP_WRITE; wdata_d = {dev_q, 1'b1}; end
      S_MEM:             begin op_d = OP_WRITE; wdata_d = addr_q; end
      S_WDATA:           begin op_d = OP_WRITE; wdata_d = wr_data; end
      S_RDATA:  op_d = (remaining_q == 16'd1) ? OP_READ_NACK : OP_READ_ACK;
      S_STOP, S_POLL_STOP, S_ERR_STOP: op_d = OP_STOP;
      default:  bus_state = 1'b0;
    endcase

    // A payload byte is taken only in the cycle it becomes the WRITE primitive.
    wr_ready = (state_q == S_WDATA) && idle_phase && wr_valid;
    issue    = bus_state && idle_phase && ((state_q != S_WDATA) || wr_valid);

    case (state_q)
      S_IDLE:       if (req_valid) state_d = (req_len == 16'd0) ? S_DONE : S_START;
      S_START:      if (rsp_ok) state_d = S_DEV;
      S_DEV:        if (rsp_ok) state_d = m.m_rsp_nack ? S_ERR_STOP : S_MEM;
      S_MEM:        if (rsp_ok) state_d = m.m_rsp_nack ? S_ERR_STOP : (rw_q ? S_RSTART : S_WDATA);
      S_WDATA: begin
        // addr/remaining already advanced when the byte was issued.
        if (rsp_ok) begin
          if (m.m_rsp_nack) state_d = S_ERR_STOP;
          else if ((remaining_q == 16'd0) || (addr_q[PB-1:0] == '0)) state_d = S_STOP;
        end
      end
      S_STOP:       if (rsp_ok) state_d = rw_q ? S_DONE : S_POLL_START;
      S_POLL_START: if (rsp_ok) state_d = S_POLL_DEV;
      S_POLL_DEV:   if (rsp_ok) state_d = (m.m_rsp_nack && last_poll) ? S_ERR_STOP : S_POLL_STOP;
      S_POLL_STOP: begin
        // poll_cnt is cleared by an ACK, so zero here means the device answered.
        if (rsp_ok) begin
          if (poll_cnt_q != '0)           state_d = S_POLL_START;
          else if (remaining_q != 16'd0)  state_d = S_START;
          else                            state_d = S_DONE;
        end
      end
      S_RSTART:     if (rsp_ok) state_d = S_DEV_R;
      S_DEV_R:      if (rsp_ok) state_d = m.m_rsp_nack ? S_ERR_STOP : S_RDATA;
      S_RDATA:      if (rsp_ok && (remaining_q == 16'd0)) state_d = S_STOP;
      S_ERR_STOP:   if (rsp_ok) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      poll_cnt_q  <= '0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      wait_rsp_q  <= 1'b0;
      op_q        <= OP_STOP;
      wdata_q     <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      if (accept) begin
        rw_q        <= req_rw;
        dev_q       <= req_dev_addr;
        addr_q      <= req_mem_addr;
        remaining_q <= req_len;
        poll_cnt_q  <= '0;
        err_q       <= 1'b0;
      end
      if (issue) begin
        cmd_valid_q <= 1'b1;
        op_q        <= op_d;
        wdata_q     <= wdata_d;
        if ((state_q == S_WDATA) || (state_q == S_RDATA)) begin
          addr_q      <= addr_q + 8'd1;
          remaining_q <= remaining_q - 16'd1;
        end
      end
      if (cmd_valid_q && m.m_cmd_ready) begin
        cmd_valid_q <= 1'b0;
        wait_rsp_q  <= 1'b1;
      end
      if (rsp_ok) begin
        wait_rsp_q <= 1'b0;
        if (state_q == S_RDATA) begin
          rd_valid <= 1'b1;
          rd_data  <= m.m_rsp_rdata;
        end
        if (state_q == S_POLL_DEV)
          poll_cnt_q <= m.m_rsp_nack ? (poll_cnt_q + PW'(1)) : '0;
      end
      if (state_q == S_ERR_STOP) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// tb/tb_i2c_eeprom_seq.sv - directed self-checking bench for i2c_eeprom_seq

module tb_i2c_eeprom_seq;
  import i2c_pkg::*;

  localparam logic [2:0] P_START = 3'd0;
  localparam logic [2:0] P_WR    = 3'd1;
  localparam logic [2:0] P_RA    = 3'd2;
  localparam logic [2:0] P_RN    = 3'd3;
  localparam logic [2:0] P_STOP  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0]  req_dev_addr = '0;
  logic [7:0]  req_mem_addr = '0;
  logic [15:0] req_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        req_ready, wr_ready, rd_valid, done, err;
  logic [7:0]  rd_data;

  always #5 clk = ~clk;

  i2c_eeprom_seq_if bus();

  i2c_eeprom_seq #(.PAGE_SIZE(16), .MAX_POLL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_mem_addr(req_mem_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .m(bus)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // EEPROM / I2C master model
  logic [7:0]  mem [256];
  int          busy = 0, busy_cfg = 0, phase = 0, pend = 0, cyc = 0;
  logic [7:0]  ptr = '0;
  bit          wrote = 0;
  logic        pend_nack = 1'b0;
  logic [7:0]  pend_rdata = '0;
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];

  task automatic slave_exec(input logic [2:0] op, input logic [7:0] b);
    log_q.push_back({op, b});
    pend_nack  = 1'b0;
    pend_rdata = '0;
    case (op)
      P_START: phase = 0;
      P_WR: begin
        if (phase == 0) begin
          if (b[7:1] != 7'h50) pend_nack = 1'b1;
          else if (busy > 0) begin pend_nack = 1'b1; busy--; end
          else phase = b[0] ? 3 : 1;
        end else if (phase == 1) begin ptr = b; phase = 2; end
        else if (phase == 2) begin mem[ptr] = b; ptr++; wrote = 1; end
        else pend_nack = 1'b1;
      end
      P_RA, P_RN: begin pend_rdata = mem[ptr]; ptr++; end
      P_STOP: begin if (wrote) busy = busy_cfg; wrote = 0; phase = 0; end
      default: ;
    endcase
  endtask

  initial begin
    bus.m_cmd_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_nack  = 1'b0;
    bus.m_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.m_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        bus.m_cmd_ready = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.m_rsp_valid = 1'b1;
            bus.m_rsp_nack  = pend_nack;
            bus.m_rsp_rdata = pend_rdata;
          end
        end
        bus.m_cmd_ready = (cyc % 3) != 0;
        if (bus.m_cmd_valid && bus.m_cmd_ready) begin
          slave_exec(bus.m_cmd_op, bus.m_cmd_wdata);
          pend = 2;
        end
      end
    end
  end

  // Output monitor
  int          done_cnt = 0, rise_cnt = 0, wr_acc = 0, wr_gap = 0;
  logic        last_err = 1'b0, prev_v = 1'b0;
  logic [7:0]  rd_q[$];
  logic [7:0]  wq[$];

  initial forever begin
    @(negedge clk);
    if (done) begin done_cnt++; last_err = err; end
    if (rd_valid) rd_q.push_back(rd_data);
    if (bus.m_cmd_valid && !prev_v) rise_cnt++;
    prev_v = bus.m_cmd_valid;
  end

  // Write payload feeder with periodic stalls
  initial forever begin
    @(negedge clk);
    wr_gap++;
    if (wq.size() > 0 && (wr_gap % 4) != 1) begin
      wr_valid = 1'b1;
      wr_data  = wq[0];
    end else begin
      wr_valid = 1'b0;
    end
    #1;
    if (wr_valid && wr_ready) begin
      void'(wq.pop_front());
      wr_acc++;
    end
  end

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] a, input logic [15:0] len);
    int t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    check("req_ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_mem_addr = a; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 2000) begin @(negedge clk); t++; end
    check({tag, "_done_seen"}, done_cnt - start, 1);
  endtask

  task automatic ex(input logic [2:0] op, input logic [7:0] b);
    exp_q.push_back({op, b});
  endtask

  task automatic ex_poll(input int n);
    for (int i = 0; i < n; i++) begin ex(P_START, 8'h00); ex(P_WR, 8'hA0); ex(P_STOP, 8'h00); end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nprims"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_prim%0d", tag, i), log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_cmd_valid"}, bus.m_cmd_valid, 1'b0);
    check({tag, "_m_cmd_op"}, bus.m_cmd_op, 3'd4);
    check({tag, "_m_cmd_wdata"}, bus.m_cmd_wdata, 8'h00);
    check({tag, "_wr_ready"}, wr_ready, 1'b0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, 8'h00);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0, rise0, t, starts;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);

    // Single-page write with three busy polls
    log_q.delete(); busy_cfg = 3;
    wq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_req(1'b0, 7'h50, 8'h3C, 16'd4);
    wait_done("wr1");
    check("wr1_err", last_err, 1'b0);
    ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_WR, 8'h3C);
    ex(P_WR, 8'hDE); ex(P_WR, 8'hAD); ex(P_WR, 8'hBE); ex(P_WR, 8'hEF); ex(P_STOP, 0);
    ex_poll(4);
    check_log("wr1");
    check("wr1_mem3c", mem[8'h3C], 8'hDE);
    check("wr1_mem3d", mem[8'h3D], 8'hAD);
    check("wr1_mem3e", mem[8'h3E], 8'hBE);
    check("wr1_mem3f", mem[8'h3F], 8'hEF);

    // Write split across a page boundary
    busy_cfg = 1;
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_req(1'b0, 7'h50, 8'h0E, 16'd4);
    wait_done("wr2");
    check("wr2_err", last_err, 1'b0);
    ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_WR, 8'h0E); ex(P_WR, 8'h11); ex(P_WR, 8'h22); ex(P_STOP, 0);
    ex_poll(2);
    ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_WR, 8'h10); ex(P_WR, 8'h33); ex(P_WR, 8'h44); ex(P_STOP, 0);
    ex_poll(2);
    check_log("wr2");
    check("wr2_mem0e", mem[8'h0E], 8'h11);
    check("wr2_mem11", mem[8'h11], 8'h44);

    // Read back four bytes
    rd_q.delete(); busy_cfg = 0;
    do_req(1'b1, 7'h50, 8'h3C, 16'd4);
    wait_done("rd1");
    check("rd1_err", last_err, 1'b0);
    ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_WR, 8'h3C); ex(P_START, 0); ex(P_WR, 8'hA1);
    ex(P_RA, 0); ex(P_RA, 0); ex(P_RA, 0); ex(P_RN, 0); ex(P_STOP, 0);
    check_log("rd1");
    check("rd1_nbytes", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      check("rd1_b0", rd_q[0], 8'hDE);
      check("rd1_b1", rd_q[1], 8'hAD);
      check("rd1_b2", rd_q[2], 8'hBE);
      check("rd1_b3", rd_q[3], 8'hEF);
    end

    // No device at 0x51
    acc0 = wr_acc;
    wq = '{8'h01, 8'h02};
    do_req(1'b0, 7'h51, 8'h00, 16'd2);
    wait_done("nack");
    check("nack_err", last_err, 1'b1);
    check("nack_wr_accepts", wr_acc - acc0, 0);
    ex(P_START, 0); ex(P_WR, 8'hA2); ex(P_STOP, 0);
    check_log("nack");
    wq.delete();

    // Poll timeout: device stays busy
    busy_cfg = 100;
    wq = '{8'h77};
    do_req(1'b0, 7'h50, 8'h20, 16'd1);
    wait_done("ptmo");
    check("ptmo_err", last_err, 1'b1);
    starts = 0;
    foreach (log_q[i]) if (log_q[i][10:8] == P_START) starts++;
    check("ptmo_poll_starts", starts - 1, 4);
    ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_WR, 8'h20); ex(P_WR, 8'h77); ex(P_STOP, 0);
    ex_poll(3); ex(P_START, 0); ex(P_WR, 8'hA0); ex(P_STOP, 0);
    check_log("ptmo");
    busy = 0; busy_cfg = 0;

    // Zero-length request
    rise0 = rise_cnt;
    do_req(1'b0, 7'h50, 8'h00, 16'd0);
    check("len0_done", done, 1'b1);
    check("len0_err", err, 1'b0);
    @(negedge clk);
    check("len0_done_pulse", done, 1'b0);
    check("len0_idle", req_ready, 1'b1);
    check("len0_no_cmds", rise_cnt - rise0, 0);

    // Reset asserted in the middle of a write
    acc0 = wr_acc;
    wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_req(1'b0, 7'h50, 8'h40, 16'd4);
    t = 0;
    while (wr_acc == acc0 && t < 200) begin @(negedge clk); t++; end
    check("mid_rst_in_wdata", wr_acc > acc0, 1'b1);
    wq.delete();
    rst_n = 1'b0;
    phase = 0; wrote = 0;
    #1;
    check("mid_rst_req_ready", req_ready, 1'b0);
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_after_ready", req_ready, 1'b1);
    check("mid_rst_after_valid", bus.m_cmd_valid, 1'b0);
    log_q.delete();
    rd_q.delete();
    do_req(1'b1, 7'h50, 8'h3C, 16'd2);
    wait_done("post_rst");
    check("post_rst_err", last_err, 1'b0);
    check("post_rst_nbytes", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("post_rst_b0", rd_q[0], 8'hDE);
      check("post_rst_b1", rd_q[1], 8'hAD);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
